// File: rtl/spi_sys_bus_master_if.sv
// Register-bus handshake between the SPI bridge (master) and a register
// responder (slave).
interface spi_sys_bus_master_if;
  logic [7:0] sys_addr;
  logic [7:0] sys_data_out;
  logic [7:0] sys_data_in;
  logic       sys_read_write;
  logic       sys_strobe;
  logic       sys_ack;

  modport master (
    output sys_addr,
    output sys_data_out,
    output sys_read_write,
    output sys_strobe,
    input  sys_data_in,
    input  sys_ack
  );

  modport slave (
    input  sys_addr,
    input  sys_data_out,
    input  sys_read_write,
    input  sys_strobe,
    output sys_data_in,
    output sys_ack
  );
endinterface

// File: rtl/spi_sys_bus_master.sv
// SPI mode-0 slave that bridges framed SPI commands onto a simple
// strobe/ack register bus. SPI inputs are oversampled by clk through
// 2-flop synchronizers; bus requests are bounded by a timeout.
module spi_sys_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy,
  output logic err_timeout,
  spi_sys_bus_master_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX_CMD   = 3'd1;
  localparam logic [2:0] S_RX_ADDR  = 3'd2;
  localparam logic [2:0] S_RX_DATA  = 3'd3;
  localparam logic [2:0] S_TX_DUMMY = 3'd4;
  localparam logic [2:0] S_TX_DATA  = 3'd5;
  localparam logic [2:0] S_IGNORE   = 3'd6;

  localparam logic [0:0] B_IDLE = 1'b0;
  localparam logic [0:0] B_REQ  = 1'b1;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_CLEAR = 8'h40;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  // Synchronizer and edge-detect state
  logic       sck_meta_r, sck_sync_r, sck_prev_r;
  logic       cs_meta_r, cs_sync_r, cs_prev_r;
  logic       mosi_meta_r, mosi_sync_r;
  logic [1:0] sync_vld_r;
  logic       cs_armed_r;

  // SPI framing state
  logic [2:0] spi_state_r;
  logic [2:0] bit_cnt_r;
  logic [6:0] rx_shift_r;
  logic       wr_r;
  logic [7:0] addr_r;
  logic [7:0] data_r;
  logic       issue_r;
  logic       clr_req_r;
  logic [7:0] tx_shift_r;
  logic       miso_r;
  logic       oe_r;

  // Bus state
  logic [0:0] bus_state_r;
  logic [7:0] tmo_cnt_r;
  logic [7:0] sys_addr_r;
  logic [7:0] sys_data_out_r;
  logic       sys_rw_r;
  logic       sys_strobe_r;
  logic [7:0] rd_data_r;
  logic       err_timeout_r;

  logic       sck_rise_s;
  logic       sck_fall_s;
  logic       cs_idle_s;
  logic       cs_fall_s;
  logic       byte_done_s;
  logic [7:0] rx_byte_s;
  logic       timeout_s;

  // Edge detection, frame qualification and timeout decode
  always_comb begin
    sck_rise_s  = sck_sync_r & ~sck_prev_r;
    sck_fall_s  = ~sck_sync_r & sck_prev_r;
    // Until cs_n has been seen high after reset, treat the bus as idle so a
    // frame already in flight at reset release is never joined half-way.
    cs_idle_s   = cs_sync_r | ~cs_armed_r;
    cs_fall_s   = cs_armed_r & cs_prev_r & ~cs_sync_r;
    rx_byte_s   = {rx_shift_r, mosi_sync_r};
    byte_done_s = sck_rise_s & (bit_cnt_r == 3'd7) & (spi_state_r != S_IDLE);
    timeout_s   = (bus_state_r == B_REQ) & ~bus.sys_ack & (tmo_cnt_r == TMO_LIMIT);
  end

  // Two-flop synchronizers plus the arm flag that gates cs_n edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_meta_r  <= 1'b0;
      sck_sync_r  <= 1'b0;
      sck_prev_r  <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      sync_vld_r  <= 2'b00;
      cs_armed_r  <= 1'b0;
    end else begin
      sck_meta_r  <= spi_sck;
      sck_sync_r  <= sck_meta_r;
      sck_prev_r  <= sck_sync_r;
      cs_meta_r   <= spi_cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
      mosi_meta_r <= spi_mosi;
      mosi_sync_r <= mosi_meta_r;
      sync_vld_r  <= {sync_vld_r[0], 1'b1};
      if (sync_vld_r[1] && cs_sync_r) begin
        cs_armed_r <= 1'b1;
      end
    end
  end

  // SPI frame FSM: byte assembly, command decode and bus-issue pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_state_r <= S_IDLE;
      bit_cnt_r   <= 3'd0;
      rx_shift_r  <= 7'd0;
      wr_r        <= 1'b0;
      addr_r      <= 8'h00;
      data_r      <= 8'h00;
      issue_r     <= 1'b0;
      clr_req_r   <= 1'b0;
    end else begin
      issue_r   <= 1'b0;
      clr_req_r <= 1'b0;
      if (cs_idle_s) begin
        spi_state_r <= S_IDLE;
        bit_cnt_r   <= 3'd0;
      end else if (cs_fall_s) begin
        spi_state_r <= S_RX_CMD;
        bit_cnt_r   <= 3'd0;
      end else if (sck_rise_s && (spi_state_r != S_IDLE)) begin
        rx_shift_r <= rx_byte_s[6:0];
        bit_cnt_r  <= bit_cnt_r + 3'd1;
        if (byte_done_s) begin
          case (spi_state_r)
            S_RX_CMD: begin
              if (rx_byte_s == CMD_READ) begin
                wr_r        <= 1'b0;
                spi_state_r <= S_RX_ADDR;
              end else if (rx_byte_s == CMD_WRITE) begin
                wr_r        <= 1'b1;
                spi_state_r <= S_RX_ADDR;
              end else if (rx_byte_s == CMD_CLEAR) begin
                clr_req_r   <= 1'b1;
                spi_state_r <= S_IGNORE;
              end else begin
                spi_state_r <= S_IGNORE;
              end
            end
            S_RX_ADDR: begin
              addr_r <= rx_byte_s;
              if (wr_r) begin
                spi_state_r <= S_RX_DATA;
              end else begin
                issue_r     <= 1'b1;
                spi_state_r <= S_TX_DUMMY;
              end
            end
            S_RX_DATA: begin
              data_r      <= rx_byte_s;
              issue_r     <= 1'b1;
              spi_state_r <= S_IGNORE;
            end
            S_TX_DUMMY: spi_state_r <= S_TX_DATA;
            S_TX_DATA:  spi_state_r <= S_IGNORE;
            default:    spi_state_r <= S_IGNORE;
          endcase
        end
      end
    end
  end

  // MISO shifter: load on byte completion, shift out on each SCK falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_r <= 8'h00;
      miso_r     <= 1'b0;
    end else if (cs_idle_s || cs_fall_s) begin
      tx_shift_r <= 8'h00;
      miso_r     <= 1'b0;
    end else if (byte_done_s) begin
      tx_shift_r <= (spi_state_r == S_TX_DUMMY) ? rd_data_r : 8'h00;
    end else if (sck_fall_s) begin
      miso_r     <= tx_shift_r[7];
      tx_shift_r <= {tx_shift_r[6:0], 1'b0};
    end
  end

  // MISO output enable follows the qualified chip select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_r <= 1'b0;
    end else begin
      oe_r <= ~cs_idle_s;
    end
  end

  // Bus FSM: hold the request until ack or until the timeout budget is spent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state_r    <= B_IDLE;
      tmo_cnt_r      <= 8'd0;
      sys_addr_r     <= 8'h00;
      sys_data_out_r <= 8'h00;
      sys_rw_r       <= 1'b0;
      sys_strobe_r   <= 1'b0;
      rd_data_r      <= 8'h00;
    end else begin
      case (bus_state_r)
        B_IDLE: begin
          if (issue_r) begin
            sys_addr_r   <= addr_r;
            sys_rw_r     <= wr_r;
            if (wr_r) begin
              sys_data_out_r <= data_r;
            end
            sys_strobe_r <= 1'b1;
            tmo_cnt_r    <= 8'd1;
            bus_state_r  <= B_REQ;
          end
        end
        B_REQ: begin
          if (bus.sys_ack) begin
            if (!sys_rw_r) begin
              rd_data_r <= bus.sys_data_in;
            end
            sys_strobe_r <= 1'b0;
            bus_state_r  <= B_IDLE;
          end else if (tmo_cnt_r == TMO_LIMIT) begin
            if (!sys_rw_r) begin
              rd_data_r <= 8'hFF;
            end
            sys_strobe_r <= 1'b0;
            bus_state_r  <= B_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        default: begin
          sys_strobe_r <= 1'b0;
          bus_state_r  <= B_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a timeout in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout_r <= 1'b0;
    end else if (timeout_s) begin
      err_timeout_r <= 1'b1;
    end else if (clr_req_r) begin
      err_timeout_r <= 1'b0;
    end
  end

  assign spi_miso           = miso_r;
  assign spi_miso_oe        = oe_r;
  assign busy               = sys_strobe_r;
  assign err_timeout        = err_timeout_r;
  assign bus.sys_addr       = sys_addr_r;
  assign bus.sys_data_out   = sys_data_out_r;
  assign bus.sys_read_write = sys_rw_r;
  assign bus.sys_strobe     = sys_strobe_r;

endmodule
